// File: rtl/ls_unit_pkg.sv
// rtl/ls_unit_pkg.sv - shared widths, LS op codes and op helpers for the load/store unit
package ls_unit_pkg;

    localparam int DataWidth = 32;
    localparam int ImmWidth  = 32;

    typedef logic [5:0] op_id_t;
    typedef logic [3:0] rob_id_t;

    localparam op_id_t OP_LB  = 6'd1;
    localparam op_id_t OP_LH  = 6'd2;
    localparam op_id_t OP_LW  = 6'd3;
    localparam op_id_t OP_LBU = 6'd4;
    localparam op_id_t OP_LHU = 6'd5;
    localparam op_id_t OP_SB  = 6'd6;
    localparam op_id_t OP_SH  = 6'd7;
    localparam op_id_t OP_SW  = 6'd8;

    function automatic logic op_is_store(input op_id_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/ls_extend.sv
// rtl/ls_extend.sv - load-data extension and store-data masking/length per LS op
module ls_extend
    import ls_unit_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] rdata,
    input  logic [31:0] rs2,
    output logic [31:0] load_value,
    output logic [31:0] store_data,
    output logic [1:0]  len
);

    always_comb begin
        load_value = rdata;
        store_data = rs2;
        len        = 2'd0;
        case (op)
            OP_LB:  load_value = {{24{rdata[7]}}, rdata[7:0]};
            OP_LH:  begin
                load_value = {{16{rdata[15]}}, rdata[15:0]};
                len        = 2'd1;
            end
            OP_LW:  len = 2'd3;
            OP_LBU: load_value = {24'b0, rdata[7:0]};
            OP_LHU: begin
                load_value = {16'b0, rdata[15:0]};
                len        = 2'd1;
            end
            OP_SB:  store_data = {24'b0, rs2[7:0]};
            OP_SH:  begin
                store_data = {16'b0, rs2[15:0]};
                len        = 2'd1;
            end
            OP_SW:  len = 2'd3;
            default: begin
                load_value = rdata;
                store_data = rs2;
                len        = 2'd0;
            end
        endcase
    end

endmodule

// File: rtl/ls_unit.sv
// rtl/ls_unit.sv - single-entry load/store unit between the LSB, ROB and memory controller
module ls_unit
    import ls_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        LSB_valid,
    input  logic [5:0]  LSB_OP_ID,
    input  logic [31:0] LSB_inst_pc,
    input  logic [31:0] LSB_reg_rs1,
    input  logic [31:0] LSB_reg_rs2,
    input  logic [31:0] LSB_imm,
    input  logic [3:0]  LSB_ROB_id,
    output logic        LSB_ready,
    output logic        MC_req_valid,
    output logic        MC_req_wr,
    output logic [31:0] MC_req_addr,
    output logic [1:0]  MC_req_len,
    output logic [31:0] MC_req_data,
    input  logic        MC_done,
    input  logic [31:0] MC_rdata,
    output logic        ROB_output_valid,
    output logic [3:0]  ROB_output_id,
    output logic [31:0] ROB_output_value,
    input  logic        ROB_commit_store,
    input  logic [3:0]  ROB_commit_id,
    input  logic        ROB_roll_back_flag
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_COMMIT = 2'd1,
        S_MEM         = 2'd2,
        S_DRAIN       = 2'd3
    } state_t;

    state_t      state, state_next;
    op_id_t      op_q;
    rob_id_t     id_q;
    logic [31:0] rs2_q;
    logic [31:0] addr_q;
    logic [31:0] load_value;
    logic        accept;
    logic        store_q;
    logic        unused_pc;

    // The pc is carried for interface symmetry with the LSB; nothing here consumes it.
    assign unused_pc = ^LSB_inst_pc;

    assign accept  = LSB_valid & LSB_ready;
    assign store_q = op_is_store(op_q);

    ls_extend u_ext (
        .op         (op_q),
        .rdata      (MC_rdata),
        .rs2        (rs2_q),
        .load_value (load_value),
        .store_data (MC_req_data),
        .len        (MC_req_len)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (rdy) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = op_is_store(LSB_OP_ID) ? S_WAIT_COMMIT : S_MEM;
                end
            end
            S_WAIT_COMMIT: begin
                if (ROB_roll_back_flag) begin
                    state_next = S_IDLE;
                end else if (ROB_commit_store && (ROB_commit_id == id_q)) begin
                    state_next = S_MEM;
                end
            end
            S_MEM: begin
                if (MC_done) begin
                    state_next = S_IDLE;
                end else if (ROB_roll_back_flag) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (MC_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        LSB_ready    = (state == S_IDLE) && !ROB_roll_back_flag;
        MC_req_valid = (state == S_MEM) || (state == S_DRAIN);
        MC_req_wr    = MC_req_valid && store_q;
    end

    assign MC_req_addr = addr_q;

    // Stores broadcast immediately so the ROB can commit them; loads broadcast on data return.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q             <= '0;
            id_q             <= '0;
            rs2_q            <= '0;
            addr_q           <= '0;
            ROB_output_valid <= 1'b0;
            ROB_output_id    <= '0;
            ROB_output_value <= '0;
        end else if (rdy) begin
            ROB_output_valid <= 1'b0;
            if (accept) begin
                op_q   <= LSB_OP_ID;
                id_q   <= LSB_ROB_id;
                rs2_q  <= LSB_reg_rs2;
                addr_q <= LSB_reg_rs1 + LSB_imm;
                if (op_is_store(LSB_OP_ID)) begin
                    ROB_output_valid <= 1'b1;
                    ROB_output_id    <= LSB_ROB_id;
                    ROB_output_value <= '0;
                end
            end
            if ((state == S_MEM) && MC_done && !ROB_roll_back_flag && !store_q) begin
                ROB_output_valid <= 1'b1;
                ROB_output_id    <= id_q;
                ROB_output_value <= load_value;
            end
        end
    end

endmodule

// File: tb/tb_ls_unit.sv
// tb/tb_ls_unit.sv - directed self-checking bench for ls_unit with a transaction-level model
module tb_ls_unit;
    import ls_unit_pkg::*;

    logic        clk, rst, rdy;
    logic        LSB_valid;
    logic [5:0]  LSB_OP_ID;
    logic [31:0] LSB_inst_pc, LSB_reg_rs1, LSB_reg_rs2, LSB_imm;
    logic [3:0]  LSB_ROB_id;
    logic        LSB_ready;
    logic        MC_req_valid, MC_req_wr;
    logic [31:0] MC_req_addr, MC_req_data;
    logic [1:0]  MC_req_len;
    logic        MC_done;
    logic [31:0] MC_rdata;
    logic        ROB_output_valid;
    logic [3:0]  ROB_output_id;
    logic [31:0] ROB_output_value;
    logic        ROB_commit_store;
    logic [3:0]  ROB_commit_id;
    logic        ROB_roll_back_flag;

    ls_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .LSB_valid(LSB_valid), .LSB_OP_ID(LSB_OP_ID), .LSB_inst_pc(LSB_inst_pc),
        .LSB_reg_rs1(LSB_reg_rs1), .LSB_reg_rs2(LSB_reg_rs2), .LSB_imm(LSB_imm),
        .LSB_ROB_id(LSB_ROB_id), .LSB_ready(LSB_ready),
        .MC_req_valid(MC_req_valid), .MC_req_wr(MC_req_wr), .MC_req_addr(MC_req_addr),
        .MC_req_len(MC_req_len), .MC_req_data(MC_req_data),
        .MC_done(MC_done), .MC_rdata(MC_rdata),
        .ROB_output_valid(ROB_output_valid), .ROB_output_id(ROB_output_id),
        .ROB_output_value(ROB_output_value),
        .ROB_commit_store(ROB_commit_store), .ROB_commit_id(ROB_commit_id),
        .ROB_roll_back_flag(ROB_roll_back_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    bit          m_ready, m_req_valid, m_req_wr, m_bc_valid;
    logic [31:0] m_addr, m_data, m_bc_value;
    logic [1:0]  m_len;
    logic [3:0]  m_bc_id;
    bit          p_store_wait, p_mem, p_drain, p_store;
    logic [5:0]  p_op;
    logic [3:0]  p_id;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [1:0] len_of(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 2'd0;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2'd1;
        return 2'd3;
    endfunction

    function automatic logic [31:0] load_val(input logic [5:0] op, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[7:0];
        h = rd[15:0];
        case (op)
            OP_LB:   return 32'($signed(b));
            OP_LH:   return 32'($signed(h));
            OP_LBU:  return 32'(b);
            OP_LHU:  return 32'(h);
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] store_mask(input logic [5:0] op, input logic [31:0] v);
        int nbytes;
        logic [63:0] mask;
        nbytes = int'(len_of(op)) + 1;
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        return v & mask[31:0];
    endfunction

    function automatic bit is_st(input logic [5:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    task automatic model_reset();
        m_ready = 1; m_req_valid = 0; m_req_wr = 0; m_bc_valid = 0;
        m_addr = 0; m_data = 0; m_len = 0; m_bc_id = 0; m_bc_value = 0;
        p_store_wait = 0; p_mem = 0; p_drain = 0; p_store = 0; p_op = 0; p_id = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else if (rdy) m_bc_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic offer(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [3:0] id);
        bit was_ready;
        was_ready = m_ready;
        LSB_valid = 1; LSB_OP_ID = op; LSB_reg_rs1 = rs1; LSB_reg_rs2 = rs2;
        LSB_imm = imm; LSB_ROB_id = id; LSB_inst_pc = 32'h1000 + 32'(id);
        step();
        LSB_valid = 0;
        if (was_ready) begin
            p_op = op; p_id = id; p_store = is_st(op);
            m_addr = rs1 + imm; m_len = len_of(op); m_data = store_mask(op, rs2);
            m_ready = 0;
            if (p_store) begin
                m_bc_valid = 1; m_bc_id = id; m_bc_value = 0;
                p_store_wait = 1;
            end else begin
                p_mem = 1; m_req_valid = 1; m_req_wr = 0;
            end
        end
    endtask

    task automatic commit(input logic [3:0] id);
        ROB_commit_store = 1; ROB_commit_id = id;
        step();
        ROB_commit_store = 0;
        if (p_store_wait && id == p_id) begin
            p_store_wait = 0; p_mem = 1; m_req_valid = 1; m_req_wr = 1;
        end
    endtask

    task automatic done(input logic [31:0] rd, input bit rb);
        MC_done = 1; MC_rdata = rd; ROB_roll_back_flag = rb;
        step();
        MC_done = 0; ROB_roll_back_flag = 0;
        if (p_mem) begin
            if (!p_store && !p_drain && !rb) begin
                m_bc_valid = 1; m_bc_id = p_id; m_bc_value = load_val(p_op, rd);
            end
            p_mem = 0; p_drain = 0; m_req_valid = 0; m_req_wr = 0; m_ready = 1;
        end
    endtask

    task automatic rollback();
        ROB_roll_back_flag = 1;
        step();
        ROB_roll_back_flag = 0;
        if (p_store_wait) begin
            p_store_wait = 0; m_ready = 1;
        end else if (p_mem) begin
            p_drain = 1;
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("lsb_ready", 32'(LSB_ready), 32'(m_ready && !ROB_roll_back_flag));
            chk("req_valid", 32'(MC_req_valid), 32'(m_req_valid));
            if (m_req_valid) begin
                chk("req_wr", 32'(MC_req_wr), 32'(m_req_wr));
                chk("req_addr", MC_req_addr, m_addr);
                chk("req_len", 32'(MC_req_len), 32'(m_len));
                if (m_req_wr) chk("req_data", MC_req_data, m_data);
            end
            chk("bc_valid", 32'(ROB_output_valid), 32'(m_bc_valid));
            if (m_bc_valid) begin
                chk("bc_id", 32'(ROB_output_id), 32'(m_bc_id));
                chk("bc_value", ROB_output_value, m_bc_value);
            end
        end
    end

    initial begin
        rst = 1; rdy = 1; LSB_valid = 0; LSB_OP_ID = 0; LSB_inst_pc = 0;
        LSB_reg_rs1 = 0; LSB_reg_rs2 = 0; LSB_imm = 0; LSB_ROB_id = 0;
        MC_done = 0; MC_rdata = 0; ROB_commit_store = 0; ROB_commit_id = 0;
        ROB_roll_back_flag = 0;
        model_reset();
        idle(2);
        chk("rst_ready", 32'(LSB_ready), 32'd1);
        chk("rst_req_valid", 32'(MC_req_valid), 32'd0);
        chk("rst_req_wr", 32'(MC_req_wr), 32'd0);
        chk("rst_bc_valid", 32'(ROB_output_valid), 32'd0);
        chk("rst_addr", MC_req_addr, 32'd0);
        chk("rst_data", MC_req_data, 32'd0);
        chk("rst_value", ROB_output_value, 32'd0);
        rst = 0;
        check_en = 1;
        idle(1);

        // LB with negative offset
        offer(OP_LB, 32'h100, 32'h0, 32'hFFFFFFFC, 4'd2);
        chk("lb_addr", MC_req_addr, 32'h000000FC);
        chk("lb_len", 32'(MC_req_len), 32'd0);
        idle(2);
        done(32'h00000080, 0);
        chk("lb_value", ROB_output_value, 32'hFFFFFF80);
        chk("lb_ready_after", 32'(LSB_ready), 32'd1);

        // LHU back-to-back
        offer(OP_LHU, 32'h2000, 32'h0, 32'h2, 4'd3);
        chk("lhu_addr", MC_req_addr, 32'h00002002);
        chk("lhu_len", 32'(MC_req_len), 32'd1);
        done(32'h1234F00D, 0);
        chk("lhu_value", ROB_output_value, 32'h0000F00D);

        // LH sign extension, unaligned LW
        offer(OP_LH, 32'h10, 32'h0, 32'h0, 4'd9);
        done(32'hABCD8001, 0);
        chk("lh_value", ROB_output_value, 32'hFFFF8001);
        offer(OP_LW, 32'h1000, 32'h0, 32'h3, 4'd10);
        chk("lw_unaligned_addr", MC_req_addr, 32'h00001003);
        done(32'h89ABCDEF, 0);

        // SW waits for its own commit; an offer meanwhile is ignored
        offer(OP_SW, 32'h40, 32'hDEADBEEF, 32'h10, 4'd5);
        chk("sw_bc_id", 32'(ROB_output_id), 32'd5);
        chk("sw_bc_value", ROB_output_value, 32'd0);
        idle(2);
        offer(OP_LW, 32'h500, 32'h0, 32'h0, 4'd6);
        commit(4'd4);
        chk("sw_no_req_wrong_id", 32'(MC_req_valid), 32'd0);
        commit(4'd5);
        chk("sw_data", MC_req_data, 32'hDEADBEEF);
        chk("sw_len", 32'(MC_req_len), 32'd3);
        idle(1);
        done(32'h0, 0);
        chk("sw_no_bc", 32'(ROB_output_valid), 32'd0);

        // SH masking
        offer(OP_SH, 32'h10, 32'hCAFEBABE, 32'h1, 4'd7);
        commit(4'd7);
        chk("sh_data", MC_req_data, 32'h0000BABE);
        done(32'h0, 0);

        // Rollback while a load is in memory
        offer(OP_LW, 32'h800, 32'h0, 32'h4, 4'd8);
        rollback();
        chk("drain_ready", 32'(LSB_ready), 32'd0);
        idle(2);
        done(32'h55555555, 0);
        chk("drain_no_bc", 32'(ROB_output_valid), 32'd0);
        chk("drain_ready_after", 32'(LSB_ready), 32'd1);

        // Rollback of an uncommitted SB, then immediate LW
        offer(OP_SB, 32'h20, 32'h000000AA, 32'h0, 4'd11);
        rollback();
        offer(OP_LW, 32'h30, 32'h0, 32'h0, 4'd12);
        chk("after_rb_lw_accepted", 32'(MC_req_valid), 32'd1);
        done(32'h0BADF00D, 0);

        // Rollback together with MC_done
        offer(OP_LBU, 32'h40, 32'h0, 32'h1, 4'd13);
        done(32'h000000FF, 1);
        chk("rb_done_no_bc", 32'(ROB_output_valid), 32'd0);

        // rdy stall mid-load, then stall holding the broadcast pulse
        offer(OP_LW, 32'h300, 32'h0, 32'h4, 4'd14);
        idle(1);
        rdy = 0;
        idle(3);
        chk("stall_req_addr", MC_req_addr, 32'h00000304);
        rdy = 1;
        done(32'h11223344, 0);
        rdy = 0;
        idle(3);
        chk("stall_bc_held", 32'(ROB_output_valid), 32'd1);
        chk("stall_bc_value", ROB_output_value, 32'h11223344);
        rdy = 1;
        idle(1);

        // Reset mid-transaction, and reset while rdy is low
        offer(OP_LW, 32'h600, 32'h0, 32'h0, 4'd1);
        rst = 1;
        step();
        rst = 0;
        chk("midrst_req_valid", 32'(MC_req_valid), 32'd0);
        chk("midrst_addr", MC_req_addr, 32'd0);
        offer(OP_SW, 32'h700, 32'h12345678, 32'h0, 4'd2);
        rdy = 0; rst = 1;
        step();
        rdy = 1; rst = 0;
        chk("rdyrst_bc_valid", 32'(ROB_output_valid), 32'd0);
        chk("rdyrst_ready", 32'(LSB_ready), 32'd1);
        idle(2);

        check_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
